kovacs_phase_decoder: RTL and testbench

KOVACS_PHASE_DECODER -- requirements
Module: kovacs_phase_decoder

---
 rtl/kovacs_phase_decoder.sv | 203 ++++++++++++++++++++
 tb/tb_kovacs_phase_decoder.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kovacs_phase_decoder.sv
// Hysteresis phase decoder: tracks HIGH/LOW phases of an indicator line and reports phase length and data sum.
// Optional accumulator (sum_o) is built only when KOVACS_DECODER_ACCUM_EN is defined.
module kovacs_phase_decoder (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic signed [15:0] indicator_i,
    input  logic signed [15:0] data_i,
    input  logic signed [15:0] thr_high_i,
    input  logic signed [15:0] thr_low_i,
    input  logic        [31:0] timeout_i,
    output logic        [1:0]  state_o,
    output logic        [31:0] half_period_o,
    output logic signed [47:0] sum_o,
    output logic               sum_state_o,
    output logic        [31:0] cycles_o,
    output logic               valid_o,
    output logic               locked_o,
    output logic               timeout_o
);

    localparam logic [1:0] ST_ACQUIRE = 2'd0;
    localparam logic [1:0] ST_HIGH    = 2'd1;
    localparam logic [1:0] ST_LOW     = 2'd2;

    // Stage 1: input registers
    logic signed [15:0] ind_q, thr_hi_q, thr_lo_q;
    logic        [31:0] timeout_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ind_q     <= '0;
            thr_hi_q  <= '0;
            thr_lo_q  <= '0;
            timeout_q <= '0;
        end else begin
            ind_q     <= indicator_i;
            thr_hi_q  <= thr_high_i;
            thr_lo_q  <= thr_low_i;
            timeout_q <= timeout_i;
        end
    end

    // Stage 2: hysteresis level; stage 3: registered edge flag
    logic level_q, level_d, level_prev_q;
    logic edge_q, rise_q;

    always_comb begin
        level_d = level_q;
        if (ind_q > thr_hi_q) begin
            level_d = 1'b1;
        end else if (ind_q < thr_lo_q) begin
            level_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            edge_q       <= 1'b0;
            rise_q       <= 1'b0;
        end else begin
            level_q      <= level_d;
            level_prev_q <= level_q;
            edge_q       <= (level_q != level_prev_q);
            rise_q       <= level_q;
        end
    end

    // Phase FSM
    logic [1:0]  state_q, state_d;
    logic [31:0] count_q, count_d;
    logic [31:0] hp_q, hp_d;
    logic        sst_q, sst_d;
    logic [31:0] cycles_q, cycles_d;
    logic        valid_q, valid_d;
    logic        locked_q, locked_d;
    logic        tmo_q, tmo_d;
    logic        reported_q, reported_d;
    logic        load_acc, add_acc;
    logic [31:0] count_inc;

    assign count_inc = (count_q == 32'hFFFF_FFFF) ? count_q : count_q + 32'd1;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        hp_d       = hp_q;
        sst_d      = sst_q;
        cycles_d   = cycles_q;
        valid_d    = 1'b0;
        locked_d   = locked_q;
        tmo_d      = 1'b0;
        reported_d = reported_q;
        load_acc   = 1'b0;
        add_acc    = 1'b0;
        case (state_q)
            ST_ACQUIRE: begin
                if (edge_q) begin
                    state_d  = rise_q ? ST_HIGH : ST_LOW;
                    count_d  = 32'd1;
                    load_acc = 1'b1;
                end
            end
            default: begin
                if (edge_q) begin
                    hp_d       = count_q;
                    sst_d      = (state_q == ST_HIGH);
                    valid_d    = 1'b1;
                    reported_d = 1'b1;
                    // A report while one is already on record is the second in a row
                    if (reported_q) begin
                        locked_d = 1'b1;
                    end
                    if (state_q == ST_LOW && rise_q) begin
                        cycles_d = cycles_q + 32'd1;
                    end
                    state_d  = rise_q ? ST_HIGH : ST_LOW;
                    count_d  = 32'd1;
                    load_acc = 1'b1;
                end else if (timeout_q != 32'd0 && count_q >= timeout_q) begin
                    tmo_d      = 1'b1;
                    state_d    = ST_ACQUIRE;
                    locked_d   = 1'b0;
                    reported_d = 1'b0;
                end else begin
                    count_d = count_inc;
                    add_acc = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_ACQUIRE;
            count_q    <= '0;
            hp_q       <= '0;
            sst_q      <= 1'b0;
            cycles_q   <= '0;
            valid_q    <= 1'b0;
            locked_q   <= 1'b0;
            tmo_q      <= 1'b0;
            reported_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            hp_q       <= hp_d;
            sst_q      <= sst_d;
            cycles_q   <= cycles_d;
            valid_q    <= valid_d;
            locked_q   <= locked_d;
            tmo_q      <= tmo_d;
            reported_q <= reported_d;
        end
    end

`ifdef KOVACS_DECODER_ACCUM_EN
    // Data rides a three-deep delay so it lines up with edge_q
    logic signed [15:0] data1_q, data2_q, data3_q;
    logic signed [47:0] acc_q, sum_q;
    logic signed [47:0] data_ext;

    assign data_ext = {{32{data3_q[15]}}, data3_q};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data1_q <= '0;
            data2_q <= '0;
            data3_q <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
        end else begin
            data1_q <= data_i;
            data2_q <= data1_q;
            data3_q <= data2_q;
            if (valid_d) begin
                sum_q <= acc_q;
            end
            if (load_acc) begin
                acc_q <= data_ext;
            end else if (add_acc) begin
                acc_q <= acc_q + data_ext;
            end
        end
    end

    assign sum_o = sum_q;
`else
    logic unused_accum;
    assign unused_accum = ^{data_i, load_acc, add_acc};
    assign sum_o = '0;
`endif

    assign state_o       = state_q;
    assign half_period_o = hp_q;
    assign sum_state_o   = sst_q;
    assign cycles_o      = cycles_q;
    assign valid_o       = valid_q;
    assign locked_o      = locked_q;
    assign timeout_o     = tmo_q;

endmodule

// File: tb/tb_kovacs_phase_decoder.sv
// Scoreboard bench for kovacs_phase_decoder: a sample-level reference model queues the expected
// per-sample outputs; a monitor pops and compares them as the DUT produces them.
module tb_kovacs_phase_decoder;

    logic               clk_i = 1'b0;
    logic               rst_i = 1'b1;
    logic signed [15:0] indicator_i = '0;
    logic signed [15:0] data_i = '0;
    logic signed [15:0] thr_high_i = 16'sd1000;
    logic signed [15:0] thr_low_i = -16'sd1000;
    logic        [31:0] timeout_i = '0;
    logic        [1:0]  state_o;
    logic        [31:0] half_period_o;
    logic signed [47:0] sum_o;
    logic               sum_state_o;
    logic        [31:0] cycles_o;
    logic               valid_o;
    logic               locked_o;
    logic               timeout_o;

    kovacs_phase_decoder dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .indicator_i   (indicator_i),
        .data_i        (data_i),
        .thr_high_i    (thr_high_i),
        .thr_low_i     (thr_low_i),
        .timeout_i     (timeout_i),
        .state_o       (state_o),
        .half_period_o (half_period_o),
        .sum_o         (sum_o),
        .sum_state_o   (sum_state_o),
        .cycles_o      (cycles_o),
        .valid_o       (valid_o),
        .locked_o      (locked_o),
        .timeout_o     (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          due;
        logic [1:0]  st;
        bit          v;
        bit          t;
        logic [31:0] hp;
        longint      sum;
        bit          sst;
        logic [31:0] cy;
        bit          lk;
    } rec_t;

    rec_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;

    // Reference model state (phase: 0 acquire, 1 high, 2 low)
    int          m_thr_h, m_thr_l;
    longint      m_tmo;
    bit          m_level;
    int          m_phase;
    longint      m_count;
    longint      m_sum;
    int          m_reps;
    bit          m_locked;
    logic [31:0] m_cycles;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] sx48(input logic [47:0] v);
        return {{16{v[47]}}, v};
    endfunction

    function automatic int rnd(input int lo, input int hi);
        return lo + int'($urandom_range(0, hi - lo));
    endfunction

    task automatic model_reset();
        m_level  = 1'b0;
        m_phase  = 0;
        m_count  = 0;
        m_sum    = 0;
        m_reps   = 0;
        m_locked = 1'b0;
        m_cycles = '0;
    endtask

    task automatic model_step(input int ind, input int dat);
        rec_t r;
        bit   nl;
        bit   edge_seen;
        nl = m_level;
        if (ind > m_thr_h) nl = 1'b1;
        else if (ind < m_thr_l) nl = 1'b0;
        edge_seen = (nl != m_level);
        m_level = nl;
        r.v = 1'b0; r.t = 1'b0; r.hp = '0; r.sum = 0; r.sst = 1'b0;
        if (m_phase == 0) begin
            if (edge_seen) begin
                m_phase = nl ? 1 : 2;
                m_count = 1;
                m_sum   = dat;
            end
        end else if (edge_seen) begin
            r.v   = 1'b1;
            r.hp  = m_count[31:0];
            r.sum = m_sum;
            r.sst = (m_phase == 1);
            if (m_phase == 2 && nl) m_cycles = m_cycles + 32'd1;
            m_reps++;
            if (m_reps >= 2) m_locked = 1'b1;
            m_phase = nl ? 1 : 2;
            m_count = 1;
            m_sum   = dat;
        end else if (m_tmo != 0 && m_count >= m_tmo) begin
            r.t      = 1'b1;
            m_phase  = 0;
            m_locked = 1'b0;
            m_reps   = 0;
        end else begin
            if (m_count < 64'h0000_0000_FFFF_FFFF) m_count++;
            m_sum += dat;
        end
        r.st  = 2'(m_phase);
        r.cy  = m_cycles;
        r.lk  = m_locked;
        r.due = cyc + 4;
        q.push_back(r);
    endtask

    task automatic drive(input int ind, input int dat);
        @(negedge clk_i);
        indicator_i = 16'(ind);
        data_i      = 16'(dat);
        model_step(ind, dat);
    endtask

    task automatic seg(input int ind, input int n, input int dat);
        for (int i = 0; i < n; i++) drive(ind, dat);
    endtask

    task automatic do_reset(input int th, input int tl, input int tm);
        @(negedge clk_i);
        rst_i = 1'b1;
        indicator_i = '0;
        data_i = '0;
        thr_high_i = 16'(th);
        thr_low_i = 16'(tl);
        timeout_i = 32'(tm);
        m_thr_h = th;
        m_thr_l = tl;
        m_tmo = tm;
        q.delete();
        model_reset();
        @(negedge clk_i);
        chk("rst_state", 64'(state_o), 64'd0);
        chk("rst_half_period", 64'(half_period_o), 64'd0);
        chk("rst_sum", sx48(sum_o), 64'd0);
        chk("rst_sum_state", 64'(sum_state_o), 64'd0);
        chk("rst_cycles", 64'(cycles_o), 64'd0);
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_locked", 64'(locked_o), 64'd0);
        chk("rst_timeout", 64'(timeout_o), 64'd0);
        rst_i = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (q.size() != 0 && guard < 20) begin
            @(negedge clk_i);
            guard++;
        end
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending records, expected 0", q.size());
        end
    endtask

    // Monitor: one record per DUT output cycle
    initial begin
        rec_t r;
        logic [47:0] s48;
        forever begin
            @(posedge clk_i);
            #1;
            cyc++;
            while (q.size() != 0 && q[0].due < cyc) begin
                r = q.pop_front();
                n_vec++;
                n_err++;
                $display("FAIL missed_record: got no check at cycle %0d, expected one at %0d", cyc, r.due);
            end
            if (q.size() != 0 && q[0].due == cyc) begin
                r = q.pop_front();
                chk("state", 64'(state_o), 64'(r.st));
                chk("valid", 64'(valid_o), 64'(r.v));
                chk("timeout", 64'(timeout_o), 64'(r.t));
                chk("cycles", 64'(cycles_o), 64'(r.cy));
                chk("locked", 64'(locked_o), 64'(r.lk));
                if (r.v) begin
`ifdef KOVACS_DECODER_ACCUM_EN
                    s48 = r.sum[47:0];
`else
                    s48 = '0;
`endif
                    chk("half_period", 64'(half_period_o), 64'(r.hp));
                    chk("sum", sx48(sum_o), sx48(s48));
                    chk("sum_state", 64'(sum_state_o), 64'(r.sst));
                    $display("report cycle=%0d half_period=%0d sum=%0d sum_state=%0d cycles=%0d locked=%0d",
                             cyc, half_period_o, sum_o, sum_state_o, cycles_o, locked_o);
                end
            end else begin
                chk("idle_valid", 64'(valid_o), 64'd0);
            end
        end
    end

    initial begin
        int th, tl, tm, kind, len;
        do_reset(1000, -1000, 0);

        // Square wave, 100 samples per phase, data 5
        seg(-8000, 20, 5);
        for (int c = 0; c < 3; c++) begin
            seg(8000, 100, 5);
            seg(-8000, 100, 5);
        end
        seg(8000, 5, 5);
        drain();

        // Indicator parked in the hysteresis band after HIGH
        do_reset(1000, -1000, 0);
        seg(-8000, 10, 3);
        seg(8000, 20, 3);
        for (int i = 0; i < 150; i++) drive(rnd(-500, 500), 3);
        seg(-8000, 5, 3);
        drain();

        // Timeout of 50 during a 200-sample phase
        do_reset(1000, -1000, 50);
        seg(-8000, 10, 1);
        seg(8000, 200, 1);
        seg(-8000, 20, 2);
        seg(8000, 30, 4);
        seg(-8000, 10, 1);
        drain();

        // Reset in mid-phase
        do_reset(1000, -1000, 0);
        seg(8000, 30, 7);
        seg(-8000, 40, 7);
        seg(8000, 10, 7);
        do_reset(1000, -1000, 0);
        seg(-8000, 5, -2);
        seg(8000, 50, -2);
        seg(-8000, 50, -2);
        seg(8000, 5, -2);
        drain();

        // Ten full LOW/HIGH cycles
        do_reset(1000, -1000, 0);
        seg(-8000, 5, 9);
        seg(8000, 50, 9);
        for (int c = 0; c < 10; c++) begin
            seg(-8000, 50, 9);
            seg(8000, 50, 9);
        end
        drain();
        chk("ten_cycles", 64'(cycles_o), 64'd10);
        chk("ten_half_period", 64'(half_period_o), 64'd50);

        // Randomized segments with random thresholds and timeout
        for (int trial = 0; trial < 6; trial++) begin
            th = rnd(0, 3000);
            tl = -rnd(1, 3000);
            tm = ($urandom_range(0, 1) == 0) ? 0 : rnd(10, 60);
            do_reset(th, tl, tm);
            for (int s = 0; s < 30; s++) begin
                kind = rnd(0, 2);
                len  = rnd(1, 80);
                for (int i = 0; i < len; i++) begin
                    case (kind)
                        0: drive(rnd(th + 1, 20000), rnd(-32768, 32767));
                        1: drive(rnd(-20000, tl - 1), rnd(-32768, 32767));
                        default: drive(rnd(tl, th), rnd(-32768, 32767));
                    endcase
                end
            end
            drain();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
